// File: rtl/alu_simd_pkg.sv
// Shared constants and helpers for the pipelined three-operand SIMD adder.
// The group size is derived from the per-beat mode; each lane carries 2 bits forward.
package alu_simd_pkg;

    localparam int CARRY_W = 2;

    // Mode encodings as seen with LANES=4; wider modes saturate to single lanes.
    localparam int MODE_FULL    = 0;
    localparam int MODE_PAIRS   = 1;
    localparam int MODE_SINGLES = 2;

    function automatic int group_size(input int mode, input int lanes);
        int g;
        g = lanes >> mode;
        return (g < 1) ? 1 : g;
    endfunction

endpackage

// File: rtl/alu_simd_lane_stage.sv
// One lane of the SIMD adder: W+X+Y+carry for lane LANE_IDX, plus the stage register.
// Latency: 1 cycle (registered sum, carry, valid and beat side-band).
// Backpressure: all state holds while en=0; bubbles shift through like beats.
module alu_simd_lane_stage
    import alu_simd_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int LANE_W   = 8,
    parameter int MODE_W   = $clog2(LANES) + 1,
    parameter int LANE_IDX = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               beat_vld,
    input  logic [MODE_W-1:0]  beat_mode,
    input  logic               beat_cin,
    input  logic [CARRY_W-1:0] carry_prev,
    input  logic [LANE_W-1:0]  w_lane,
    input  logic [LANE_W-1:0]  x_lane,
    input  logic [LANE_W-1:0]  y_lane,
    output logic               vld_q,
    output logic [MODE_W-1:0]  mode_q,
    output logic               cin_q,
    output logic [CARRY_W-1:0] carry_q,
    output logic [LANE_W-1:0]  sum_q
);

    int                     grp;
    logic                   head;
    logic                   full;
    logic [CARRY_W-1:0]     cin_lane;
    logic [LANE_W+1:0]      t;

    always_comb begin
        grp      = group_size(int'(beat_mode), LANES);
        head     = (LANE_IDX & (grp - 1)) == 0;
        full     = int'(beat_mode) == MODE_FULL;
        cin_lane = '0;
        // Only the head of a full-width group sees CIN; other heads start clean.
        if (head) begin
            cin_lane = full ? {1'b0, beat_cin} : 2'b00;
        end else begin
            cin_lane = carry_prev;
        end
        t = {2'b00, w_lane} + {2'b00, x_lane} + {2'b00, y_lane}
          + {{LANE_W{1'b0}}, cin_lane};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            mode_q  <= '0;
            cin_q   <= 1'b0;
            carry_q <= '0;
            sum_q   <= '0;
        end else if (en) begin
            vld_q   <= beat_vld;
            mode_q  <= beat_mode;
            cin_q   <= beat_cin;
            carry_q <= t[LANE_W+1:LANE_W];
            sum_q   <= t[LANE_W-1:0];
        end
    end

endmodule

// File: rtl/alu_simd_pipe.sv
// Pipelined three-operand SIMD adder S = W+X+Y+CIN with per-beat lane grouping.
// Latency: LANES cycles from accepted beat to out_valid; one beat per cycle.
// Backpressure: out_valid & ~out_ready freezes the whole pipe and drops in_ready.
module alu_simd_pipe
    import alu_simd_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int LANE_W = 8,
    parameter int MODE_W = $clog2(LANES) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MODE_W-1:0]         USE_SIMD,
    input  logic [LANES*LANE_W-1:0]   W,
    input  logic [LANES*LANE_W-1:0]   X,
    input  logic [LANES*LANE_W-1:0]   Y,
    input  logic                      CIN,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*LANE_W-1:0]   S,
    output logic [CARRY_W*LANES-1:0]  COUT
);

    localparam int DATA_W = LANES * LANE_W;
    localparam int COUT_W = CARRY_W * LANES;

    logic stall;
    logic en;

    // *_view[s]: what stage s sees (operands) or has finished (sums, carries).
    logic [DATA_W-1:0]  w_view    [LANES];
    logic [DATA_W-1:0]  x_view    [LANES];
    logic [DATA_W-1:0]  y_view    [LANES];
    logic [DATA_W-1:0]  sum_view  [LANES];
    logic [COUT_W-1:0]  cout_view [LANES];

    logic               vld_v   [LANES];
    logic [MODE_W-1:0]  mode_v  [LANES];
    logic               cin_v   [LANES];
    logic [CARRY_W-1:0] carry_v [LANES];
    logic [LANE_W-1:0]  sum_v   [LANES];

    assign stall    = out_valid & ~out_ready;
    assign en       = ~stall;
    assign in_ready = en;

    for (genvar s = 0; s < LANES; s++) begin : g_stage
        logic               beat_vld;
        logic [MODE_W-1:0]  beat_mode;
        logic               beat_cin;
        logic [CARRY_W-1:0] carry_prev;

        if (s == 0) begin : g_first
            assign beat_vld     = in_valid;
            assign beat_mode    = USE_SIMD;
            assign beat_cin     = CIN;
            assign carry_prev   = '0;
            assign w_view[0]    = W;
            assign x_view[0]    = X;
            assign y_view[0]    = Y;
            assign sum_view[0]  = DATA_W'(sum_v[0]);
            assign cout_view[0] = COUT_W'(carry_v[0]);
        end else begin : g_next
            logic [DATA_W-1:0] w_q;
            logic [DATA_W-1:0] x_q;
            logic [DATA_W-1:0] y_q;
            logic [DATA_W-1:0] sum_dk_q;
            logic [COUT_W-1:0] cout_dk_q;

            // Operand skew and result deskew, aligned with the stage register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    w_q       <= '0;
                    x_q       <= '0;
                    y_q       <= '0;
                    sum_dk_q  <= '0;
                    cout_dk_q <= '0;
                end else if (en) begin
                    w_q       <= w_view[s-1];
                    x_q       <= x_view[s-1];
                    y_q       <= y_view[s-1];
                    sum_dk_q  <= sum_view[s-1];
                    cout_dk_q <= cout_view[s-1];
                end
            end

            assign beat_vld     = vld_v[s-1];
            assign beat_mode    = mode_v[s-1];
            assign beat_cin     = cin_v[s-1];
            assign carry_prev   = carry_v[s-1];
            assign w_view[s]    = w_q;
            assign x_view[s]    = x_q;
            assign y_view[s]    = y_q;
            // Lanes >= s of the deskew register are always zero, so OR merges cleanly.
            assign sum_view[s]  = sum_dk_q  | (DATA_W'(sum_v[s])   << (s * LANE_W));
            assign cout_view[s] = cout_dk_q | (COUT_W'(carry_v[s]) << (s * CARRY_W));
        end

        alu_simd_lane_stage #(
            .LANES    (LANES),
            .LANE_W   (LANE_W),
            .MODE_W   (MODE_W),
            .LANE_IDX (s)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .beat_vld   (beat_vld),
            .beat_mode  (beat_mode),
            .beat_cin   (beat_cin),
            .carry_prev (carry_prev),
            .w_lane     (w_view[s][s*LANE_W +: LANE_W]),
            .x_lane     (x_view[s][s*LANE_W +: LANE_W]),
            .y_lane     (y_view[s][s*LANE_W +: LANE_W]),
            .vld_q      (vld_v[s]),
            .mode_q     (mode_v[s]),
            .cin_q      (cin_v[s]),
            .carry_q    (carry_v[s]),
            .sum_q      (sum_v[s])
        );
    end

    assign out_valid = vld_v[LANES-1];
    assign S         = sum_view[LANES-1];
    assign COUT      = cout_view[LANES-1];

endmodule

// File: tb/tb_alu_simd_pipe.sv
// Scoreboard bench for alu_simd_pipe: directed cases plus randomized beats under backpressure.
module tb_alu_simd_pipe;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int MODE_W = 3;
    localparam int DW     = LANES * LANE_W;
    localparam int CW     = 2 * LANES;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [MODE_W-1:0] use_simd = '0;
    logic [DW-1:0]     w = '0;
    logic [DW-1:0]     x = '0;
    logic [DW-1:0]     y = '0;
    logic              cin = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DW-1:0]     s_out;
    logic [CW-1:0]     cout;

    alu_simd_pipe #(.LANES(LANES), .LANE_W(LANE_W), .MODE_W(MODE_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .USE_SIMD  (use_simd),
        .W         (w),
        .X         (x),
        .Y         (y),
        .CIN       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (s_out),
        .COUT      (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] s;
        logic [CW-1:0] co;
        int            acc;
        bit            lat;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   stall_seen = 0;
    int   valid_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Reference: each group is one wide addition; lane k's sum and carry are read off the running prefix.
    function automatic void model(input int mode, input logic [DW-1:0] wv, input logic [DW-1:0] xv,
                                  input logic [DW-1:0] yv, input bit c,
                                  output logic [DW-1:0] sv, output logic [CW-1:0] cv);
        int     g;
        int     k;
        longint p;
        g  = LANES >> mode;
        if (g < 1) g = 1;
        sv = '0;
        cv = '0;
        for (int h = 0; h < LANES; h += g) begin
            p = (g == LANES && c) ? 64'sd1 : 64'sd0;
            for (int n = 0; n < g; n++) begin
                k = h + n;
                p += (longint'(wv[k*LANE_W +: LANE_W]) + longint'(xv[k*LANE_W +: LANE_W])
                      + longint'(yv[k*LANE_W +: LANE_W])) << (n * LANE_W);
                sv[k*LANE_W +: LANE_W] = LANE_W'(p >> (n * LANE_W));
                cv[2*k +: 2]           = 2'(p >> ((n + 1) * LANE_W));
            end
        end
    endfunction

    // Call at posedge+#1; returns at posedge+#1 right after the accepting edge.
    task automatic send(input logic [MODE_W-1:0] m, input logic [DW-1:0] wv, input logic [DW-1:0] xv,
                        input logic [DW-1:0] yv, input logic c, input bit lat);
        exp_t e;
        int   budget;
        bit   done;
        budget   = 0;
        done     = 0;
        in_valid = 1'b1;
        use_simd = m;
        w = wv; x = xv; y = yv; cin = c;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                model(int'(m), wv, xv, yv, c, e.s, e.co);
                e.acc = cyc;
                e.lat = lat;
                exp_q.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
            if (!done) begin
                budget++;
                if (budget > 200) begin
                    chk("send_timeout_in_ready", 64'(in_ready), 1);
                    done = 1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending", 64'(exp_q.size()), 0);
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        bit            prev_stall;
        logic [DW-1:0] held_s;
        logic [CW-1:0] held_c;
        exp_t          e;
        prev_stall = 0;
        held_s     = '0;
        held_c     = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !out_valid) begin
                prev_stall = 0;
            end else begin
                valid_seen++;
                chk("in_ready_follows_out_ready", 64'(in_ready), 64'(out_ready));
                if (!out_ready) stall_seen++;
                if (prev_stall) begin
                    chk("stall_hold_S", 64'(s_out), 64'(held_s));
                    chk("stall_hold_COUT", 64'(cout), 64'(held_c));
                end
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 64'(out_valid), 0);
                end else begin
                    if (exp_q[0].lat) begin
                        chk("latency", 64'(cyc - exp_q[0].acc), LANES);
                        exp_q[0].lat = 0;
                    end
                    if (out_ready) begin
                        e = exp_q.pop_front();
                        chk("S", 64'(s_out), 64'(e.s));
                        chk("COUT", 64'(cout), 64'(e.co));
                    end
                end
                prev_stall = !out_ready;
                held_s     = s_out;
                held_c     = cout;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cnt;
        bit rand_done;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_in_ready", 64'(in_ready), 1);
        chk("rst_S", 64'(s_out), 0);
        chk("rst_COUT", 64'(cout), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full chain with CIN
        send(3'd0, 32'h0000_00FF, 32'h0000_0001, 32'h0, 1'b1, 1'b1);
        drain();

        // Pairs then full on the very next cycle
        @(posedge clk); #1;
        send(3'd1, 32'h0000_FFFF, 32'h0000_0001, 32'h0, 1'b0, 1'b1);
        send(3'd0, 32'h0000_FFFF, 32'h0000_0001, 32'h0, 1'b0, 1'b1);
        // Three-operand maximum, full then singles
        send(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        // Singles with CIN ignored
        send(3'd2, 32'h0101_0101, 32'h0101_0101, 32'h0, 1'b1, 1'b1);
        drain();

        // Backpressure: 3-cycle stall from the first out_valid
        @(posedge clk); #1;
        base = stall_seen;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(3'(i % 3), 32'h1111_1111 * (i + 1), 32'h0F0F_0F0F + i, 32'h00FF_00FF, 1'(i), 1'b0);
            end
            begin
                int n;
                n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!out_valid && n < 100);
                chk("bp_first_out_valid", 64'(out_valid), 1);
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_stall_cycles", 64'(stall_seen - base), 3);

        // Reset mid-stream with results still in flight
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(3'd0, 32'h1234_5678, 32'h1111_1111, 32'h0, 1'b0, 1'b0);
        send(3'd1, 32'hAAAA_AAAA, 32'h5555_5555, 32'h1, 1'b1, 1'b0);
        send(3'd2, 32'hDEAD_BEEF, 32'h0, 32'hFF, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("t5_vld_before_reset", 64'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_out_valid", 64'(out_valid), 0);
        chk("t5_async_S", 64'(s_out), 0);
        chk("t5_async_COUT", 64'(cout), 0);
        chk("t5_in_ready_in_reset", 64'(in_ready), 1);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        base = valid_seen;
        repeat (8) @(posedge clk);
        #1;
        chk("t5_no_stale_results", 64'(valid_seen - base), 0);
        send(3'd0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b1, 1'b1);
        drain();

        // Randomized beats, modes and backpressure
        @(posedge clk); #1;
        rand_done = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
